framebuffer_write_queue: RTL and testbench
==========================================

Name: framebuffer_write_queue

Overview:
- Downstream stage of the VGA test pattern generator; sits between any framebuffer writer and the framebuffer RAM write port.
- Accepts single-cycle write strobes (address + 8-bit colour) and buffers them in a small FIFO.
- Drains the FIFO to memory under a ready/valid handshake, so memory stalls never lose writes.
- Discards out-of-range addresses and reports overflow and drop statistics.

Parameters:
- ADDR_WIDTH, 19: width of write_address and mem_address.
- DATA_WIDTH, 8: width of colour data.
- DEPTH_LOG2, 4: log2 of FIFO depth; default depth is 16 entries.
- FB_SIZE, 307200: number of valid framebuffer locations (640x480). Addresses >= FB_SIZE are rejected.

Ports:
- vga_clock  input  1  single clock for all logic.
- reset  input  1  synchronous, active-high reset.
- write_signal  input  1  write strobe; every cycle it is high is one write request.
- write_address  input  ADDR_WIDTH  target framebuffer address.
- write_data  input  DATA_WIDTH  colour value.
- mem_write_enable  output  1  head entry valid toward memory.
- mem_address  output  ADDR_WIDTH  head entry address.
- mem_data  output  DATA_WIDTH  head entry data.
- mem_ready  input  1  memory accepts the head entry this cycle.
- fifo_count  output  DEPTH_LOG2+1  current number of occupied entries.
- overflow  output  1  sticky flag: a write was dropped because the FIFO was full.
- overflow_clear  input  1  clears overflow and drop_count.
- drop_count  output  16  saturating count of dropped writes (overflow plus out-of-range).

Behaviour:
- Reset (sampled at posedge vga_clock while reset=1):
  - Pointers and count go to 0; FIFO is flushed, including during active draining.
  - mem_write_enable=0, mem_address=0, mem_data=0, overflow=0, drop_count=0.
  - Entry storage contents need not be cleared.
- Push: write_signal=1 and write_address < FB_SIZE and (count < depth, or a pop happens in the same cycle).
- Pop: mem_write_enable=1 and mem_ready=1. The head advances at the next edge.
- Output timing:
  - mem_write_enable = (count != 0); mem_address/mem_data = head entry.
  - All three are registered: a write pushed at edge N into an empty FIFO appears on the outputs in cycle N+1 (1-cycle latency).
  - When the FIFO is empty, mem_address and mem_data hold their last values.
- Ordering: strict FIFO order; no reordering or merging, except as described under Optional Feature.
- Simultaneous push and pop: count unchanged. This is legal when full, and the write is accepted.
- Full without a pop: the write is dropped, overflow is set to 1, and drop_count increments.
- Out-of-range address (>= FB_SIZE): the write is dropped and drop_count increments; overflow is not set.
- drop_count saturates at 16'hFFFF.
- overflow_clear=1:
  - Zeroes overflow and drop_count at the next edge.
  - If a drop event occurs in the same cycle, clear wins and the count goes to 0.
- Pointers wrap modulo depth. fifo_count ranges 0..depth, and depth is representable.
- mem_ready while mem_write_enable=0 is ignored.
- No state machine beyond the FIFO. Occupancy states are EMPTY (count=0), PARTIAL, and FULL (count=depth), with transitions driven only by push/pop.

Optional Feature:
- Macro: FRAMEBUFFER_WRITE_COALESCE_EN.
- When defined, a valid write whose address equals the most recently pushed (tail) entry overwrites that entry's data instead of pushing. This applies only if:
  - count >= 1, and
  - the tail entry is not the head being popped in this cycle.
- A coalesced write never sets overflow, even when the FIFO is full.
- When undefined, every valid write pushes a new entry (plain FIFO behaviour).

Test Plan:
- Reset, then 3 writes: (0,0x11), (1,0x22), (2,0x33) with mem_ready=1 → mem_write_enable rises 1 cycle after the first strobe; memory sees addresses 0,1,2 with matching data in order; fifo_count returns to 0.
- mem_ready=0, 17 writes to addresses 0..16 → fifo_count=16, overflow=1, drop_count=1. Then mem_ready=1 → exactly addresses 0..15 drain.
- FIFO full with mem_ready=1 and a simultaneous write to 100 → accepted; count stays 16, overflow stays 0, and 100 drains last.
- Write to address 307200 → not enqueued; drop_count=1, overflow=0. Then overflow_clear pulse → drop_count=0.
- Reset asserted with 8 entries queued → next cycle mem_write_enable=0 and fifo_count=0. Writes after reset drain normally.
- With FRAMEBUFFER_WRITE_COALESCE_EN and mem_ready=0, writes (5,0xAA) then (5,0xBB) → fifo_count=1; on drain, memory sees a single write (5,0xBB). Without the macro → two writes, 0xAA then 0xBB.

Source files
------------

// File: rtl/framebuffer_write_queue.sv
// framebuffer_write_queue
//   Buffers single-cycle framebuffer write strobes in a small FIFO and drains
//   them to the framebuffer RAM write port under a ready/valid handshake.
//   Writes to addresses >= FB_SIZE are discarded. Writes that arrive while the
//   FIFO is full with no pop are dropped. Both kinds of drop are counted.
//
//   Optional build macro: FRAMEBUFFER_WRITE_COALESCE_EN
//     When defined, a write to the same address as the tail entry overwrites
//     the tail's data instead of pushing a new entry.
//
// Ports
//   vga_clock        clock for all logic
//   reset            synchronous, active-high reset
//   write_signal     write strobe (one request per high cycle)
//   write_address    target framebuffer address
//   write_data       colour value
//   mem_write_enable head entry valid toward memory (registered)
//   mem_address      head entry address (registered, holds when empty)
//   mem_data         head entry data (registered, holds when empty)
//   mem_ready        memory accepts the head entry this cycle
//   fifo_count       occupied entries, 0..depth
//   overflow         sticky: a write was dropped because the FIFO was full
//   overflow_clear   clears overflow and drop_count
//   drop_count       saturating count of dropped writes
module framebuffer_write_queue #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int FB_SIZE    = 307200
) (
  input  logic                  vga_clock,
  input  logic                  reset,
  input  logic                  write_signal,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  mem_ready,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overflow,
  input  logic                  overflow_clear,
  output logic [15:0]           drop_count
);

  localparam int unsigned           DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   ONE_CNT  = (DEPTH_LOG2+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] FB_LIMIT = ADDR_WIDTH'(FB_SIZE);

  typedef logic [DEPTH_LOG2-1:0] ptr_t;

  logic [ADDR_WIDTH-1:0] addr_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];

  ptr_t                  wr_ptr_q, wr_ptr_d;
  ptr_t                  rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  ovf_q, ovf_d;
  logic [15:0]           drop_q, drop_d;

  logic in_range, valid, pop, push, coalesce, store, drop_full, drop_any;
  ptr_t tail_idx, store_idx;

  always_comb begin
    in_range = write_address < FB_LIMIT;
    valid    = write_signal && in_range;
    pop      = we_q && mem_ready;
    tail_idx = wr_ptr_q - 1'b1;

`ifdef FRAMEBUFFER_WRITE_COALESCE_EN
    // The tail may only be rewritten if it is not leaving as the head now.
    coalesce = valid && (count_q != '0) && (addr_mem_q[tail_idx] == write_address)
               && !(pop && (count_q == ONE_CNT));
`else
    coalesce = 1'b0;
`endif

    push      = valid && !coalesce && ((count_q != FULL_CNT) || pop);
    drop_full = valid && !coalesce && !push;
    drop_any  = drop_full || (write_signal && !in_range);
    store     = push || coalesce;
    store_idx = coalesce ? tail_idx : wr_ptr_q;

    wr_ptr_d = push ? ptr_t'(wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_t'(rd_ptr_q + 1'b1) : rd_ptr_q;

    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;

    // Outputs are registered, so they present the head as it will be after
    // this edge; bypass the storage when that head is being written now.
    we_d   = (count_d != '0);
    addr_d = addr_q;
    data_d = data_q;
    if (we_d) begin
      if (store && (store_idx == rd_ptr_d)) begin
        addr_d = write_address;
        data_d = write_data;
      end else begin
        addr_d = addr_mem_q[rd_ptr_d];
        data_d = data_mem_q[rd_ptr_d];
      end
    end

    if (overflow_clear) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end else begin
      ovf_d  = ovf_q | drop_full;
      drop_d = (drop_any && (drop_q != '1)) ? drop_q + 16'd1 : drop_q;
    end
  end

  always_ff @(posedge vga_clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  // Entry storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge vga_clock) begin
    if (store) begin
      addr_mem_q[store_idx] <= write_address;
      data_mem_q[store_idx] <= write_data;
    end
  end

  assign mem_write_enable = we_q;
  assign mem_address      = addr_q;
  assign mem_data         = data_q;
  assign fifo_count       = count_q;
  assign overflow         = ovf_q;
  assign drop_count       = drop_q;

endmodule

// File: tb/tb_framebuffer_write_queue.sv
// Testbench for framebuffer_write_queue: randomized and directed stimulus
// against a queue-based reference model; a negedge monitor compares every
// memory transfer and the status outputs against the model.
module tb_framebuffer_write_queue;
  localparam int AW    = 19;
  localparam int DW    = 8;
  localparam int DL    = 4;
  localparam int FBS   = 307200;
  localparam int DEPTH = 16;

  logic          vga_clock = 1'b0;
  logic          reset;
  logic          write_signal;
  logic [AW-1:0] write_address;
  logic [DW-1:0] write_data;
  logic          mem_write_enable;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data;
  logic          mem_ready;
  logic [DL:0]   fifo_count;
  logic          overflow;
  logic          overflow_clear;
  logic [15:0]   drop_count;

  framebuffer_write_queue #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH_LOG2(DL),
    .FB_SIZE   (FBS)
  ) dut (
    .vga_clock       (vga_clock),
    .reset           (reset),
    .write_signal    (write_signal),
    .write_address   (write_address),
    .write_data      (write_data),
    .mem_write_enable(mem_write_enable),
    .mem_address     (mem_address),
    .mem_data        (mem_data),
    .mem_ready       (mem_ready),
    .fifo_count      (fifo_count),
    .overflow        (overflow),
    .overflow_clear  (overflow_clear),
    .drop_count      (drop_count)
  );

  always #5 vga_clock = ~vga_clock;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  // Reference model: the queue holds exactly the writes memory still owes.
  ent_t        fifo_m[$];
  bit          m_ovf  = 1'b0;
  int unsigned m_drop = 0;

  int nvec = 0;
  int nerr = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update at the clock edge. Any pop this cycle was already removed
  // by the monitor, so "room available" is simply size < DEPTH, and a tail
  // that is leaving cannot be coalesced into (the queue is empty then).
  always @(posedge vga_clock) begin
    bit drop_ev, ovf_ev;
    ent_t t;
    drop_ev = 1'b0;
    ovf_ev  = 1'b0;
    if (reset) begin
      fifo_m.delete();
      m_ovf  = 1'b0;
      m_drop = 0;
    end else begin
      if (write_signal) begin
        if (int'(write_address) >= FBS) begin
          drop_ev = 1'b1;
`ifdef FRAMEBUFFER_WRITE_COALESCE_EN
        end else if (fifo_m.size() > 0 && fifo_m[fifo_m.size()-1].a == write_address) begin
          t   = fifo_m.pop_back();
          t.d = write_data;
          fifo_m.push_back(t);
`endif
        end else if (fifo_m.size() < DEPTH) begin
          t.a = write_address;
          t.d = write_data;
          fifo_m.push_back(t);
        end else begin
          drop_ev = 1'b1;
          ovf_ev  = 1'b1;
        end
      end
      if (overflow_clear) begin
        m_ovf  = 1'b0;
        m_drop = 0;
      end else begin
        if (ovf_ev) m_ovf = 1'b1;
        if (drop_ev && m_drop < 65535) m_drop++;
      end
    end
  end

  // Monitor: mid-cycle, status must match the model; a handshake pops the
  // expected entry and compares it with what memory is being shown.
  always @(negedge vga_clock) begin
    ent_t e;
    if (mon_en) begin
      check("fifo_count", 32'(fifo_count), fifo_m.size());
      check("mem_write_enable", 32'(mem_write_enable), 32'(fifo_m.size() != 0));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("drop_count", 32'(drop_count), m_drop);
    end
    if (mem_ready && fifo_m.size() != 0) begin
      e = fifo_m.pop_front();
      if (mon_en) begin
        check("mem_address", 32'(mem_address), 32'(e.a));
        check("mem_data", 32'(mem_data), 32'(e.d));
      end
    end
  end

  task automatic tick();
    @(posedge vga_clock);
    #2;
  endtask

  task automatic wr(input int a, input int d);
    write_signal  = 1'b1;
    write_address = AW'(a);
    write_data    = DW'(d);
    tick();
    write_signal  = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    write_signal   = 1'b0;
    write_address  = '0;
    write_data     = '0;
    mem_ready      = 1'b0;
    overflow_clear = 1'b0;
    tick();
    tick();
    reset  = 1'b0;
    mon_en = 1'b1;
    check("reset_count", 32'(fifo_count), 0);
    check("reset_we", 32'(mem_write_enable), 0);
    check("reset_addr", 32'(mem_address), 0);
    check("reset_data", 32'(mem_data), 0);

    // Three writes with memory always ready
    mem_ready = 1'b1;
    check("we_before_first", 32'(mem_write_enable), 0);
    wr(0, 8'h11);
    check("we_after_first", 32'(mem_write_enable), 1);
    wr(1, 8'h22);
    wr(2, 8'h33);
    repeat (5) tick();
    check("drain3_count", 32'(fifo_count), 0);

    // Fill past full with memory stalled
    mem_ready = 1'b0;
    for (int i = 0; i < 17; i++) wr(i, 8'h40 + i);
    check("full_count", 32'(fifo_count), 16);
    check("full_overflow", 32'(overflow), 1);
    check("full_drop", 32'(drop_count), 1);
    mem_ready = 1'b1;
    repeat (20) tick();
    check("full_drained", 32'(fifo_count), 0);
    overflow_clear = 1'b1;
    tick();
    overflow_clear = 1'b0;
    check("clear_overflow", 32'(overflow), 0);

    // Full FIFO accepts a write in the same cycle as a pop
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) wr(200 + i, i);
    mem_ready = 1'b1;
    wr(100, 8'h99);
    mem_ready = 1'b0;
    check("pushpop_full_count", 32'(fifo_count), 16);
    check("pushpop_full_ovf", 32'(overflow), 0);
    mem_ready = 1'b1;
    repeat (20) tick();

    // Out-of-range address
    wr(FBS, 8'h55);
    check("oor_drop", 32'(drop_count), 1);
    check("oor_overflow", 32'(overflow), 0);
    check("oor_count", 32'(fifo_count), 0);
    overflow_clear = 1'b1;
    tick();
    overflow_clear = 1'b0;
    check("oor_cleared", 32'(drop_count), 0);

    // Reset while entries are queued
    mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(300 + i, i);
    check("pre_reset_count", 32'(fifo_count), 8);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("flush_we", 32'(mem_write_enable), 0);
    check("flush_count", 32'(fifo_count), 0);
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) wr(400 + i, 8'hC0 + i);
    repeat (6) tick();

    // Same address twice while stalled
    mem_ready = 1'b0;
    wr(5, 8'hAA);
    wr(5, 8'hBB);
`ifdef FRAMEBUFFER_WRITE_COALESCE_EN
    check("same_addr_count", 32'(fifo_count), 1);
`else
    check("same_addr_count", 32'(fifo_count), 2);
`endif
    mem_ready = 1'b1;
    repeat (5) tick();

    // Randomized traffic, alternating stall-heavy and drain-heavy phases
    for (int i = 0; i < 3000; i++) begin
      int r;
      write_signal = ($urandom_range(0, 9) < 6);
      r = $urandom_range(0, 19);
      if (r < 16)       write_address = AW'(r % 6);
      else if (r == 16) write_address = AW'(FBS - 1);
      else if (r == 17) write_address = AW'(FBS);
      else if (r == 18) write_address = 19'h7FFFF;
      else              write_address = AW'($urandom_range(0, FBS - 1));
      write_data = DW'($urandom);
      if ((i / 200) % 2 == 0) mem_ready = ($urandom_range(0, 3) == 0);
      else                    mem_ready = ($urandom_range(0, 3) != 0);
      overflow_clear = ($urandom_range(0, 49) == 0);
      reset          = ($urandom_range(0, 499) == 0);
      tick();
    end
    write_signal   = 1'b0;
    overflow_clear = 1'b0;
    reset          = 1'b0;
    mem_ready      = 1'b1;
    repeat (30) tick();
    check("final_empty", 32'(fifo_count), 0);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
